// File: rtl/x_delay_decode.sv
// Delay-line edge decoder with windowed statistics (mean/min/max/bubble count).
// Decoded samples feed a two-state accumulate/hold engine with a valid/ready result port.
module x_delay_decode #(
    parameter int DW       = 32,
    parameter int WIN_LOG2 = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DW-1:0]       i_data,
    input  logic                i_data_vld,
    input  logic                i_clr,
    output logic [5:0]          o_pos,
    output logic                o_bubble,
    output logic                o_pos_vld,
    output logic                o_res_vld,
    input  logic                i_res_rdy,
    output logic [5:0]          o_avg,
    output logic [5:0]          o_min,
    output logic [5:0]          o_max,
    output logic [WIN_LOG2:0]   o_bub_cnt,
    output logic                o_ovf
);

    localparam int SW = 6 + WIN_LOG2;
    localparam int CW = WIN_LOG2 + 1;
    localparam logic [DW-1:0] INV_MASK = {(DW/2){2'b10}};
    localparam logic [CW-1:0] WIN_LEN  = {1'b1, {WIN_LOG2{1'b0}}};

    typedef enum logic {ACC, HOLD} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sum_q, sum_d, sum_in;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_in;
    logic [5:0]      min_q, min_d, min_in;
    logic [5:0]      max_q, max_d, max_in;
    logic [CW-1:0]   bcnt_q, bcnt_d, bcnt_in;
    logic            res_vld_d, ovf_d, take;
    logic [5:0]      avg_d, rmin_d, rmax_d;
    logic [CW-1:0]   rbub_d;

    logic [DW-1:0]   norm;
    logic [5:0]      dec_pos;
    logic            dec_bub, zero_seen;

    // Thermometer run length from bit 0; any 1 after the first 0 is a bubble.
    always_comb begin
        norm      = i_data ^ INV_MASK;
        dec_pos   = '0;
        dec_bub   = 1'b0;
        zero_seen = 1'b0;
        for (int unsigned i = 0; i < DW; i++) begin
            if (!norm[i])
                zero_seen = 1'b1;
            else if (zero_seen)
                dec_bub = 1'b1;
            else
                dec_pos = dec_pos + 6'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pos     <= '0;
            o_bubble  <= 1'b0;
            o_pos_vld <= 1'b0;
        end else begin
            o_pos_vld <= i_data_vld;
            if (i_data_vld) begin
                o_pos    <= dec_pos;
                o_bubble <= dec_bub;
            end
        end
    end

    assign sum_in  = sum_q + {{WIN_LOG2{1'b0}}, o_pos};
    assign cnt_in  = cnt_q + {{WIN_LOG2{1'b0}}, 1'b1};
    assign min_in  = (o_pos < min_q) ? o_pos : min_q;
    assign max_in  = (o_pos > max_q) ? o_pos : max_q;
    assign bcnt_in = bcnt_q + {{WIN_LOG2{1'b0}}, o_bubble};

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        min_d     = min_q;
        max_d     = max_q;
        bcnt_d    = bcnt_q;
        res_vld_d = o_res_vld;
        ovf_d     = o_ovf;
        avg_d     = o_avg;
        rmin_d    = o_min;
        rmax_d    = o_max;
        rbub_d    = o_bub_cnt;
        take      = 1'b0;

        if (i_clr) begin
            state_d   = ACC;
            sum_d     = '0;
            cnt_d     = '0;
            min_d     = '1;
            max_d     = '0;
            bcnt_d    = '0;
            res_vld_d = 1'b0;
            ovf_d     = 1'b0;
            avg_d     = '0;
            rmin_d    = '0;
            rmax_d    = '0;
            rbub_d    = '0;
        end else begin
            case (state_q)
                ACC:  take = o_pos_vld;
                HOLD: begin
                    // Accumulators are already cleared, so a sample coinciding
                    // with the handshake simply opens the next window.
                    if (i_res_rdy) begin
                        state_d   = ACC;
                        res_vld_d = 1'b0;
                        take      = o_pos_vld;
                    end else if (o_pos_vld) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = ACC;
            endcase
        end

        if (take) begin
            if (cnt_in == WIN_LEN) begin
                avg_d     = 6'(sum_in >> WIN_LOG2);
                rmin_d    = min_in;
                rmax_d    = max_in;
                rbub_d    = bcnt_in;
                res_vld_d = 1'b1;
                state_d   = HOLD;
                sum_d     = '0;
                cnt_d     = '0;
                min_d     = '1;
                max_d     = '0;
                bcnt_d    = '0;
            end else begin
                sum_d  = sum_in;
                cnt_d  = cnt_in;
                min_d  = min_in;
                max_d  = max_in;
                bcnt_d = bcnt_in;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ACC;
            sum_q     <= '0;
            cnt_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            bcnt_q    <= '0;
            o_res_vld <= 1'b0;
            o_ovf     <= 1'b0;
            o_avg     <= '0;
            o_min     <= '0;
            o_max     <= '0;
            o_bub_cnt <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            min_q     <= min_d;
            max_q     <= max_d;
            bcnt_q    <= bcnt_d;
            o_res_vld <= res_vld_d;
            o_ovf     <= ovf_d;
            o_avg     <= avg_d;
            o_min     <= rmin_d;
            o_max     <= rmax_d;
            o_bub_cnt <= rbub_d;
        end
    end

endmodule

// File: tb/tb_x_delay_decode.sv
// Bench for x_delay_decode: decode vector table, directed window sequences, random run
// against a queue-based reference model updated once per clock.
module tb_x_delay_decode;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_data;
    logic        i_data_vld, i_clr, i_res_rdy;
    logic [5:0]  o_pos, o_avg, o_min, o_max;
    logic        o_bubble, o_pos_vld, o_res_vld, o_ovf;
    logic [W:0]  o_bub_cnt;

    always #5 clk = ~clk;

    x_delay_decode #(.DW(32), .WIN_LOG2(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_data_vld(i_data_vld),
        .i_clr(i_clr), .o_pos(o_pos), .o_bubble(o_bubble), .o_pos_vld(o_pos_vld),
        .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_avg(o_avg), .o_min(o_min),
        .o_max(o_max), .o_bub_cnt(o_bub_cnt), .o_ovf(o_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int  m_pos, m_avg, m_min, m_max, m_bc;
    bit  m_bub, m_pvld, m_rv, m_ovf;
    int  win[$];
    bit  wbub[$];

    function automatic void ref_decode(input logic [31:0] d, output int p, output bit b);
        logic [63:0] n;
        n = {32'h0, d ^ 32'hAAAAAAAA};
        p = 0;
        while (n[p]) p++;
        b = (n >> p) != 64'd0;
    endfunction

    function automatic logic [31:0] thermo(input int p);
        logic [63:0] t;
        t = (64'd1 << p) - 64'd1;
        return t[31:0] ^ 32'hAAAAAAAA;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_bub = 0; m_pvld = 0;
        m_rv = 0; m_ovf = 0; m_avg = 0; m_min = 0; m_max = 0; m_bc = 0;
        win.delete(); wbub.delete();
    endtask

    task automatic model_push(input int p, input bit b);
        int s, mn, mx, bc;
        win.push_back(p);
        wbub.push_back(b);
        if (win.size() == N) begin
            s = 0; mn = 63; mx = 0; bc = 0;
            foreach (win[i]) begin
                s += win[i];
                if (win[i] < mn) mn = win[i];
                if (win[i] > mx) mx = win[i];
                bc += int'(wbub[i]);
            end
            m_avg = s / N; m_min = mn; m_max = mx; m_bc = bc; m_rv = 1;
            win.delete(); wbub.delete();
        end
    endtask

    task automatic model_edge();
        int p0;
        bit b0, v0;
        p0 = m_pos; b0 = m_bub; v0 = m_pvld;
        if (i_data_vld) ref_decode(i_data, m_pos, m_bub);
        m_pvld = i_data_vld;
        if (i_clr) begin
            win.delete(); wbub.delete();
            m_rv = 0; m_ovf = 0; m_avg = 0; m_min = 0; m_max = 0; m_bc = 0;
        end else if (!m_rv) begin
            if (v0) model_push(p0, b0);
        end else if (i_res_rdy) begin
            m_rv = 0;
            if (v0) model_push(p0, b0);
        end else if (v0) begin
            m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        chk("pos", 32'(o_pos), 32'(m_pos));
        chk("bubble", 32'(o_bubble), 32'(m_bub));
        chk("pos_vld", 32'(o_pos_vld), 32'(m_pvld));
        chk("res_vld", 32'(o_res_vld), 32'(m_rv));
        chk("avg", 32'(o_avg), 32'(m_avg));
        chk("min", 32'(o_min), 32'(m_min));
        chk("max", 32'(o_max), 32'(m_max));
        chk("bub_cnt", 32'(o_bub_cnt), 32'(m_bc));
        chk("ovf", 32'(o_ovf), 32'(m_ovf));
    endtask

    task automatic step(input logic [31:0] d, input logic v, input logic clr, input logic rdy);
        @(negedge clk);
        i_data = d; i_data_vld = v; i_clr = clr; i_res_rdy = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic samples(input int count, input int p, input logic rdy);
        for (int k = 0; k < count; k++) step(thermo(p), 1'b1, 1'b0, rdy);
    endtask

    task automatic chk_result(input string tag, input int vld, input int avg,
                              input int mn, input int mx, input int ovf);
        chk({tag, "_res_vld"}, 32'(o_res_vld), 32'(vld));
        chk({tag, "_avg"}, 32'(o_avg), 32'(avg));
        chk({tag, "_min"}, 32'(o_min), 32'(mn));
        chk({tag, "_max"}, 32'(o_max), 32'(mx));
        chk({tag, "_ovf"}, 32'(o_ovf), 32'(ovf));
    endtask

    typedef struct {
        logic [31:0] data;
        int          pos;
        bit          bub;
    } dvec_t;

    dvec_t tbl[8];

    initial begin
        tbl[0] = '{32'hAAAAAAAA, 0, 1'b0};
        tbl[1] = '{32'hAAAAAAA5, 4, 1'b0};
        tbl[2] = '{32'h55555555, 32, 1'b0};
        tbl[3] = '{32'hAAAAABAD, 3, 1'b1};
        tbl[4] = '{32'hAAAAAAAB, 1, 1'b0};
        tbl[5] = '{32'h2AAAAAAA, 0, 1'b1};
        tbl[6] = '{32'hD5555555, 31, 1'b0};
        tbl[7] = '{32'h55555554, 0, 1'b1};

        rst_n = 1'b0; i_data = '0; i_data_vld = 0; i_clr = 0; i_res_rdy = 0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Decode vectors
        foreach (tbl[i]) begin
            step(tbl[i].data, 1'b1, 1'b0, 1'b1);
            chk("tbl_pos", 32'(o_pos), 32'(tbl[i].pos));
            chk("tbl_bub", 32'(o_bubble), 32'(tbl[i].bub));
            chk("tbl_vld", 32'(o_pos_vld), 32'd1);
        end
        // Clear discards the last table sample arriving at the stats engine
        step('0, 1'b0, 1'b1, 1'b0);
        chk("hold_pos_after_clr", 32'(o_pos), 32'(tbl[7].pos));

        // Alternating 4/12 window
        for (int k = 0; k < N; k++) step(thermo((k % 2 == 0) ? 4 : 12), 1'b1, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        chk_result("win1", 1, 8, 4, 12, 0);
        chk("win1_bub", 32'(o_bub_cnt), 32'd0);
        step('0, 1'b0, 1'b0, 1'b1);
        chk("win1_drop", 32'(o_res_vld), 32'd0);

        // Backpressure: dropped pos-30 samples must not leak into the next window
        samples(N, 4, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk_result("bp_first", 1, 4, 4, 4, 0);
        samples(5, 30, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk_result("bp_held", 1, 4, 4, 4, 1);
        step('0, 1'b0, 1'b0, 1'b1);
        chk("bp_hs", 32'(o_res_vld), 32'd0);
        samples(N, 12, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk_result("bp_next", 1, 12, 12, 12, 1);

        // Handshake coincides with a pos-20 sample reaching the stats engine
        step(thermo(20), 1'b1, 1'b0, 1'b0);
        step(thermo(20), 1'b1, 1'b0, 1'b1);
        chk("sim_hs", 32'(o_res_vld), 32'd0);
        samples(N - 2, 20, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk_result("sim", 1, 20, 20, 20, 1);

        // Clear while holding
        step('0, 1'b0, 1'b1, 1'b0);
        chk_result("clr", 0, 0, 0, 0, 0);
        samples(N, 7, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk_result("clr_next", 1, 7, 7, 7, 0);
        step('0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-window
        samples(7, 9, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("rst_pos_vld", 32'(o_pos_vld), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_data_vld = 0;
        samples(N, 9, 1'b0);
        chk("rst_partial", 32'(o_res_vld), 32'd0);
        step('0, 1'b0, 1'b0, 1'b0);
        chk_result("rst_next", 1, 9, 9, 9, 0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] d;
            if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = thermo(int'($urandom_range(0, 32)));
            step(d, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 2),
                 $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
